// File: rtl/ram2_arbiter.sv
// Single-port ram2 access arbiter: shares one ram2 port between IF-stage fetch
// and MEM-stage load/store, and stalls the pipeline while a data access owns ram2.
module ram2_arbiter #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter int                WR_CYCLES = 2,
  parameter logic [DATA_W-1:0] NOP_INST  = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_req,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_re,
  input  logic              mem_we,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stall_req,
  output logic [ADDR_W-1:0] ram2_pc,
  input  logic [DATA_W-1:0] ram2_inst,
  output logic [ADDR_W-1:0] ram2_addr,
  output logic [DATA_W-1:0] ram2_wdata,
  input  logic [DATA_W-1:0] ram2_rdata,
  output logic              ram2_re,
  output logic              ram2_we,
  output logic              ram2_ce
);

  localparam int                WCNT_W    = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRD,
    S_DWR,
    S_DREC
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WCNT_W-1:0] r_wcnt;
  logic [DATA_W-1:0] r_if_inst;
  logic              r_if_valid;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_mem_done;
  logic              w_dreq;
  logic              w_fetch;

  // A request still held during its own mem_done cycle must not restart.
  assign w_dreq  = (mem_re | mem_we) & ~r_mem_done;
  assign w_fetch = (r_state == S_IDLE) & ~w_dreq & if_req;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_dreq && mem_we)      w_next = S_DWR;
        else if (w_dreq && mem_re) w_next = S_DRD;
      end
      S_DRD:   w_next = S_IDLE;
      S_DWR:   if (r_wcnt == WCNT_LAST) w_next = S_DREC;
      S_DREC:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are gated by rst so a store cut by reset drops WE in the same cycle.
  always_comb begin
    ram2_ce   = 1'b0;
    ram2_re   = 1'b0;
    ram2_we   = 1'b0;
    stall_req = rst & ((r_state != S_IDLE) | w_dreq);
    if (rst) begin
      case (r_state)
        S_DRD:   begin ram2_ce = 1'b1; ram2_re = 1'b1; end
        S_DWR:   begin ram2_ce = 1'b1; ram2_we = 1'b1; end
        S_DREC:  ram2_ce = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                r_wcnt <= '0;
    else if (r_state == S_DWR) r_wcnt <= r_wcnt + 1'b1;
    else                     r_wcnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_if_inst  <= NOP_INST;
      r_if_valid <= 1'b0;
    end else begin
      r_if_valid <= w_fetch;
      if (w_fetch) r_if_inst <= ram2_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem_rdata <= '0;
      r_mem_done  <= 1'b0;
    end else begin
      r_mem_done <= (r_state == S_DRD) | (r_state == S_DREC);
      if (r_state == S_DRD) r_mem_rdata <= ram2_rdata;
    end
  end

  assign ram2_pc    = if_pc;
  assign ram2_addr  = mem_addr;
  assign ram2_wdata = mem_wdata;
  assign if_inst    = r_if_inst;
  assign if_valid   = r_if_valid;
  assign mem_rdata  = r_mem_rdata;
  assign mem_done   = r_mem_done;

endmodule
